// File: rtl/cordic_seq_core.sv
// Sequential CORDIC core in rotation mode: one micro-rotation per enabled clock.
// Produces cos/sin of a Q2.(WIDTH-2) angle; flags angles beyond +/-pi/2 at capture.
module cordic_seq_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 16
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             clk_en,
   input  logic             start,
   input  logic [WIDTH-1:0] dataa,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_b,
   output logic             done,
   output logic             busy,
   output logic             range_err
);

   localparam int unsigned IW = $clog2(ITER);
   localparam int unsigned Sh = 32 - WIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   // Round a Q2.30 constant to nearest at the configured fraction width.
   function automatic logic [WIDTH-1:0] scale_q30(input logic [31:0] v);
      return WIDTH'((({2'b00, v} << 1) + (34'd1 << Sh)) >> (Sh + 1));
   endfunction

   // atan(2^-i) in Q2.30, rounded to nearest.
   function automatic logic [31:0] atan_q30(input logic [4:0] idx);
      case (idx)
         5'd0:    return 32'd843314857;
         5'd1:    return 32'd497837829;
         5'd2:    return 32'd263043837;
         5'd3:    return 32'd133525159;
         5'd4:    return 32'd67021687;
         5'd5:    return 32'd33543516;
         5'd6:    return 32'd16775851;
         5'd7:    return 32'd8388437;
         5'd8:    return 32'd4194283;
         5'd9:    return 32'd2097149;
         5'd10:   return 32'd1048576;
         default: return 32'd1 << (5'd30 - idx);
      endcase
   endfunction

   localparam logic [WIDTH-1:0] KInit  = scale_q30(32'h26DD3B6A);  // 0.6072529350
   localparam logic [WIDTH-1:0] HalfPi = scale_q30(32'h6487ED51);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [IW-1:0]    i_q, i_d;
   logic             rerr_q, rerr_d;
   logic [WIDTH-1:0] result_q, result_d, result_b_q, result_b_d;
   logic             range_err_q, range_err_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] x_sh, y_sh, atan_i, x_rot, y_rot, z_rot, mag;
   logic             in_rerr;

   // One micro-rotation datapath and input range check.
   always_comb begin
      x_sh   = $signed(x_q) >>> i_q;
      y_sh   = $signed(y_q) >>> i_q;
      atan_i = scale_q30(atan_q30(5'(i_q)));
      if (!z_q[WIDTH-1]) begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_i;
      end else begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_i;
      end
      // Magnitude as unsigned so the most negative code reads as 2.0.
      mag     = dataa[WIDTH-1] ? ('0 - dataa) : dataa;
      in_rerr = (mag > HalfPi);
   end

   // Next-state logic for the FSM, datapath registers and output registers.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      i_d         = i_q;
      rerr_d      = rerr_q;
      result_d    = result_q;
      result_b_d  = result_b_q;
      range_err_d = range_err_q;
      done_d      = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               x_d     = KInit;
               y_d     = '0;
               z_d     = dataa;
               i_d     = '0;
               rerr_d  = in_rerr;
               state_d = StRun;
            end
         end
         StRun: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            i_d = i_q + IW'(1);
            if (i_q == IW'(ITER - 1)) begin
               result_d    = x_rot;
               result_b_d  = y_rot;
               range_err_d = rerr_q;
               state_d     = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; everything holds while clk_en is low.
   always_ff @(posedge clock or negedge aclr) begin
      if (!aclr) begin
         state_q     <= StIdle;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         i_q         <= '0;
         rerr_q      <= 1'b0;
         result_q    <= '0;
         result_b_q  <= '0;
         range_err_q <= 1'b0;
         done_q      <= 1'b0;
      end else if (clk_en) begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         i_q         <= i_d;
         rerr_q      <= rerr_d;
         result_q    <= result_d;
         result_b_q  <= result_b_d;
         range_err_q <= range_err_d;
         done_q      <= done_d;
      end
   end

   assign result    = result_q;
   assign result_b  = result_b_q;
   assign range_err = range_err_q;
   assign done      = done_q;
   assign busy      = (state_q == StRun) || (state_q == StDone);

endmodule
